// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard detector: shadows EXE/MEM/WB destinations, flags RAW stalls
// against in-flight writers and counts stall cycles (saturating).
module hazard_scoreboard #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic             forward_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_read,
  output logic             hazard,
  output logic [REG_W-1:0] mem_dest,
  output logic             mem_wb_en_o,
  output logic [REG_W-1:0] wb_dest,
  output logic             wb_en_o,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_read;
  } slot_t;

  slot_t            r_exe, r_mem, r_wb;
  logic [CNT_W-1:0] r_stall_cnt;

  slot_t w_id_slot;
  logic  w_use1, w_use2;
  logic  w_m1_exe, w_m1_mem, w_m2_exe, w_m2_mem;
  logic  w_hazard, w_bubble;

  assign w_id_slot = {id_dest, id_wb_en, id_mem_read};
  assign w_use1    = id_valid;
  assign w_use2    = id_valid && two_src;

  // WB is deliberately absent: the regfile writes in the first half-cycle.
  assign w_m1_exe = r_exe.wb_en && (r_exe.dest == src1);
  assign w_m1_mem = r_mem.wb_en && (r_mem.dest == src1);
  assign w_m2_exe = r_exe.wb_en && (r_exe.dest == src2);
  assign w_m2_mem = r_mem.wb_en && (r_mem.dest == src2);

  always_comb begin
    w_hazard = 1'b0;
    if (forward_en)
      w_hazard = r_exe.mem_read && ((w_use1 && w_m1_exe) || (w_use2 && w_m2_exe));
    else
      w_hazard = (w_use1 && (w_m1_exe || w_m1_mem)) ||
                 (w_use2 && (w_m2_exe || w_m2_mem));
  end

  assign w_bubble = w_hazard || branch_taken || !id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exe       <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else if (!freeze) begin
      r_wb  <= r_mem;
      r_mem <= r_exe;
      r_exe <= w_bubble ? slot_t'('0) : w_id_slot;
      if (w_hazard && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign hazard      = w_hazard;
  assign mem_dest    = r_mem.dest;
  assign mem_wb_en_o = r_mem.wb_en;
  assign wb_dest     = r_wb.dest;
  assign wb_en_o     = r_wb.wb_en;
  assign stall_count = r_stall_cnt;

endmodule
